// File: rtl/h_sync_rx.sv
// Horizontal timing receiver: segments each TFT line, measures the segments, and reports lock and error status.
// Defining H_SYNC_RX_STATS_EN adds the saturating Line_cnt/Err_cnt statistics outputs.
module h_sync_rx #(
  parameter int EXP_PULSE  = 112,
  parameter int EXP_BP     = 144,
  parameter int EXP_PIX    = 1280,
  parameter int EXP_FP     = 27,
  parameter int TOL        = 0,
  parameter int LOCK_LINES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        HSYNC,
  input  logic        H_DE,
  output logic [10:0] Pix_x,
  output logic        Pix_valid,
  output logic        Line_start,
  output logic        Line_ok,
  output logic        Err_timing,
  output logic        Err_seq,
  output logic        Locked,
  output logic [11:0] Meas_pulse,
  output logic [11:0] Meas_bp,
  output logic [11:0] Meas_pix,
  output logic [11:0] Meas_fp
`ifdef H_SYNC_RX_STATS_EN
  ,
  output logic [15:0] Line_cnt,
  output logic [15:0] Err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, PULSE, BACK_PORCH, PIXEL, FRONT_PORCH} state_t;

  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [10:0] PIX_LAST = 11'(EXP_PIX - 1);
  localparam logic [3:0]  LOCK_TGT = 4'(LOCK_LINES);

  state_t      state;
  logic        s_hs, s_de;
  logic [11:0] seg_cnt, cur_pulse, cur_bp, cur_pix;
  logic [3:0]  lock_cnt;
  logic        hs_fall, hs_rise, de_rise, de_fall, illegal, line_good;

  function automatic logic in_tol(input logic [11:0] m, input int e);
    int d;
    d = int'(m) - e;
    return (d <= TOL) && (-d <= TOL);
  endfunction

  assign hs_fall = s_hs & ~HSYNC;
  assign hs_rise = ~s_hs & HSYNC;
  assign de_rise = ~s_de & H_DE;
  assign de_fall = s_de & ~H_DE;

  // IDLE ignores edge order so a stuck or noisy bus cannot spam Err_seq while unsynchronised.
  assign illegal = (state != IDLE) &&
                   ((H_DE && !HSYNC) ||
                    (de_rise && state != BACK_PORCH) ||
                    (de_fall && state != PIXEL) ||
                    (hs_fall && (state == BACK_PORCH || state == PIXEL)));

  assign line_good = in_tol(cur_pulse, EXP_PULSE) && in_tol(cur_bp, EXP_BP) &&
                     in_tol(cur_pix, EXP_PIX) && in_tol(seg_cnt, EXP_FP);

  // Segment counter is loaded with 1 on the entering edge, so its value on the leaving edge is the length.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      s_hs       <= 1'b0;
      s_de       <= 1'b0;
      seg_cnt    <= '0;
      cur_pulse  <= '0;
      cur_bp     <= '0;
      cur_pix    <= '0;
      lock_cnt   <= '0;
      Pix_x      <= '0;
      Pix_valid  <= 1'b0;
      Line_start <= 1'b0;
      Line_ok    <= 1'b0;
      Err_timing <= 1'b0;
      Err_seq    <= 1'b0;
      Locked     <= 1'b0;
      Meas_pulse <= '0;
      Meas_bp    <= '0;
      Meas_pix   <= '0;
      Meas_fp    <= '0;
    end else begin
      s_hs       <= HSYNC;
      s_de       <= H_DE;
      Line_start <= 1'b0;
      Line_ok    <= 1'b0;
      Err_timing <= 1'b0;
      Err_seq    <= 1'b0;
      Pix_valid  <= 1'b0;
      Pix_x      <= '0;
      if (seg_cnt != CNT_MAX) seg_cnt <= seg_cnt + 12'd1;

      if (illegal) begin
        Err_seq  <= 1'b1;
        Locked   <= 1'b0;
        lock_cnt <= '0;
        if (hs_fall) begin
          state      <= PULSE;
          Line_start <= 1'b1;
          seg_cnt    <= 12'd1;
        end else begin
          state   <= IDLE;
          seg_cnt <= '0;
        end
      end else if (state != IDLE && seg_cnt == CNT_MAX) begin
        Err_seq  <= 1'b1;
        Locked   <= 1'b0;
        lock_cnt <= '0;
        state    <= IDLE;
        seg_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            seg_cnt <= '0;
            if (hs_fall) begin
              state      <= PULSE;
              Line_start <= 1'b1;
              seg_cnt    <= 12'd1;
            end
          end
          PULSE: begin
            if (hs_rise) begin
              cur_pulse <= seg_cnt;
              state     <= BACK_PORCH;
              seg_cnt   <= 12'd1;
            end
          end
          BACK_PORCH: begin
            if (de_rise) begin
              cur_bp    <= seg_cnt;
              state     <= PIXEL;
              seg_cnt   <= 12'd1;
              Pix_valid <= 1'b1;
            end
          end
          PIXEL: begin
            if (de_fall) begin
              cur_pix <= seg_cnt;
              state   <= FRONT_PORCH;
              seg_cnt <= 12'd1;
            end else begin
              Pix_valid <= 1'b1;
              Pix_x     <= (Pix_x == PIX_LAST) ? Pix_x : Pix_x + 11'd1;
            end
          end
          FRONT_PORCH: begin
            if (hs_fall) begin
              Meas_pulse <= cur_pulse;
              Meas_bp    <= cur_bp;
              Meas_pix   <= cur_pix;
              Meas_fp    <= seg_cnt;
              Line_start <= 1'b1;
              state      <= PULSE;
              seg_cnt    <= 12'd1;
              if (line_good) begin
                Line_ok <= 1'b1;
                if (lock_cnt != LOCK_TGT) lock_cnt <= lock_cnt + 4'd1;
                if (lock_cnt >= LOCK_TGT - 4'd1) Locked <= 1'b1;
              end else begin
                Err_timing <= 1'b1;
                lock_cnt   <= '0;
                Locked     <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef H_SYNC_RX_STATS_EN
  // Counts follow the registered event pulses, so they update one clock after each event.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Line_cnt <= '0;
      Err_cnt  <= '0;
    end else begin
      if ((Line_ok || Err_timing) && Line_cnt != 16'hFFFF) Line_cnt <= Line_cnt + 16'd1;
      if ((Err_timing || Err_seq) && Err_cnt != 16'hFFFF) Err_cnt <= Err_cnt + 16'd1;
    end
  end
`endif

endmodule
